wt_arb_fsm: RTL and testbench
=============================

// Module: wt_arb_fsm
// PURPOSE
//  Write-side arbiter/sequencer in front of the async FIFO write port (wt_clk domain).
//  Shares the single push port between N_REQ requesters.
//  Uses round-robin arbitration and bounded bursts.
//  Never pushes while full; flags a push-on-full error when the owner keeps requesting while full.
// PARAMETERS
//  N_REQ      4  number of requesters (>=2)
//  DATA_W     8  FIFO write data width
//  BURST_MAX  4  max beats per grant before rotation (>=1)
// PORTS
//  wt_clk             in   1              write-domain clock; all logic on posedge
//  rst_wt             in   1              synchronous, active-high reset
//  req                in   N_REQ          per-requester push request (level, held until acked)
//  req_data           in   N_REQ*DATA_W   requester i data at [i*DATA_W +: DATA_W]
//  full               in   1              FIFO full, already synchronised into wt_clk
//  gnt                out  N_REQ          one-hot current owner (registered)
//  ack                out  N_REQ          beat accepted this cycle = gnt & {N_REQ{wt_en}}
//  wt_en              out  1              FIFO push strobe (combinational)
//  wt_data            out  DATA_W         req_data slice of owner (combinational mux)
//  push_on_full_error out  1              registered 1-cycle pulse per stalled owner request
// BEHAVIOUR
//  Reset (rst_wt=1 at posedge):
//   - state=IDLE, gnt=0, beat_cnt=0, push_on_full_error=0.
//   - last-owner pointer ptr=N_REQ-1, so req[0] has first priority.
//   - wt_en, ack, wt_data are 0 while in IDLE.
//  States:
//   IDLE
//    - Combinational outputs 0.
//    - If |req: owner <= first set req scanning ptr+1, ptr+2, ... (wrap mod N_REQ).
//    - gnt <= onehot(owner), beat_cnt <= 0, go to BURST.
//    - Latency req->gnt = 1 cycle.
//   BURST
//    - wt_en = req[owner] & ~full; wt_data = req_data[owner].
//    - full=1: no push; go to STALL; beat_cnt unchanged.
//    - wt_en=1 and beat_cnt==BURST_MAX-1: end burst.
//    - wt_en=1 otherwise: beat_cnt++.
//    - req[owner]=0: end burst (no push that cycle).
//    - End burst: ptr <= owner, gnt <= 0, go to IDLE.
//    - Rotation therefore costs exactly 1 idle cycle.
//   STALL
//    - wt_en=0; gnt held.
//    - full=0: back to BURST (the push happens in BURST, not STALL).
//    - req[owner]=0 while full: end burst as above.
//  push_on_full_error <= (state!=IDLE) & gnt-owner req & full; a pulse for every such cycle.
//  Simultaneous full + last beat: no push; the beat completes after full drops.
//  beat_cnt width = clog2(BURST_MAX)+1; it never wraps, since it is cleared on every new grant.
//  Requesters must hold req and req_data stable until ack; the arbiter never pre-empts an owner before BURST_MAX.
//  Illegal state encoding -> IDLE.
// STRUCTURE
//  Shared pkg/include (fifo_defs): state encodings IDLE/BURST/STALL, clog2 function.
//  Sub-module rr_pick #(N): combinational round-robin picker (req, ptr -> onehot, idx, any).
//  Top holds the FSM, ptr, owner, beat_cnt, gnt and error registers, plus the data mux.
// TESTING (N_REQ=4, BURST_MAX=4, DATA_W=8)
//  1 Reset:
//    rst_wt=1 for 2 cycles with req=4'b1111, full=0
//    -> gnt=0, wt_en=0, error=0 throughout;
//    -> 1 cycle after release gnt=4'b0001.
//  2 Rotation:
//    req=4'b1111 held, full=0
//    -> gnt sequence 0001,0010,0100,1000,0001;
//    -> 4 wt_en pulses each, 1 idle cycle between owners.
//  3 Early release:
//    req[0] drops after 2 acks
//    -> burst ends after 2 beats; next gnt=4'b0010.
//  4 Full stall:
//    full=1 for 3 cycles at beat 2 of req[1], req held
//    -> wt_en=0 those 3 cycles; error pulses 3 cycles, each 1 cycle late;
//    -> remaining 2 beats push after full drops; data order preserved.
//  5 Reset mid-burst:
//    rst_wt=1 during beat 3 of req[2]
//    -> next edge gnt=0, wt_en=0; restart grants req[0] first.
//  6 Single requester:
//    req=4'b0100 only
//    -> repeated 4-beat bursts to req[2] with one IDLE cycle gap; ack only on bit 2.

Source files
------------

// File: rtl/wt_arb_fsm_pkg.sv
// Shared definitions for the write-side arbiter: FSM state encodings and width helpers.
package wt_arb_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        STALL = 2'd2
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Index width that stays at least one bit even for degenerate sizes.
    function automatic int idxWidth(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wt_arb_fsm_rr_pick.sv
// Combinational round-robin picker: first set request after the last-owner pointer, wrapping.
module wt_arb_fsm_rr_pick
    import wt_arb_fsm_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           req_i,
    input  logic [idxWidth(N)-1:0] ptr_i,
    output logic [N-1:0]           onehot_o,
    output logic [idxWidth(N)-1:0] idx_o,
    output logic                   any_o
);

    localparam int IW = idxWidth(N);

    // Scan ptr+1 .. ptr+N so the previous owner is considered last.
    always_comb begin
        int cand;
        cand     = 0;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = IW'(cand);
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wt_arb_fsm.sv
// Write-port arbiter: round-robin grants, bounded bursts, full-aware push sequencing.
module wt_arb_fsm
    import wt_arb_fsm_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                    wt_clk,
    input  logic                    rst_wt,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic                    full,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic                    wt_en,
    output logic [DATA_W-1:0]       wt_data,
    output logic                    push_on_full_error
);

    localparam int IDX_W = idxWidth(N_REQ);
    localparam int CNT_W = clog2(BURST_MAX) + 1;

    arb_state_e         state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [CNT_W-1:0]   beat_q;
    logic [CNT_W-1:0]   beat_d;
    logic [N_REQ-1:0]   gnt_q;
    logic               err_q;
    logic               err_d;

    logic [N_REQ-1:0]   pickOnehot;
    logic [IDX_W-1:0]   pickIdx;
    logic               pickAny;
    logic               ownerReq;
    logic               lastBeat;
    logic               pushNow;
    logic               endBurst;
    logic [DATA_W-1:0]  ownerData;

    wt_arb_fsm_rr_pick #(.N(N_REQ)) uPick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pickOnehot),
        .idx_o    (pickIdx),
        .any_o    (pickAny)
    );

    always_comb begin
        ownerData = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                ownerData = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A burst ends on owner release, or on the final beat actually being pushed.
    always_comb begin
        ownerReq = req[owner_q];
        lastBeat = (beat_q == CNT_W'(BURST_MAX - 1));
        pushNow  = (state_q == BURST) && ownerReq && !full;
        endBurst = 1'b0;
        beat_d   = beat_q;
        err_d    = ((state_q == BURST) || (state_q == STALL)) && ownerReq && full;
        case (state_q)
            BURST:   endBurst = !ownerReq || (pushNow && lastBeat);
            STALL:   endBurst = full && !ownerReq;
            default: endBurst = 1'b0;
        endcase
        if (pushNow && !lastBeat) begin
            beat_d = beat_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wt_clk) begin
        if (rst_wt) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            owner_q <= '0;
            beat_q  <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                IDLE: begin
                    if (pickAny) begin
                        owner_q <= pickIdx;
                        gnt_q   <= pickOnehot;
                        beat_q  <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (endBurst) begin
                        ptr_q   <= owner_q;
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (full) begin
                        state_q <= STALL;
                    end else begin
                        beat_q <= beat_d;
                    end
                end
                STALL: begin
                    if (endBurst) begin
                        ptr_q   <= owner_q;
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (!full) begin
                        state_q <= BURST;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    beat_q  <= '0;
                end
            endcase
        end
    end

    assign gnt                = gnt_q;
    assign wt_en              = pushNow;
    assign ack                = gnt_q & {N_REQ{pushNow}};
    assign wt_data            = ((state_q == BURST) || (state_q == STALL)) ? ownerData : '0;
    assign push_on_full_error = err_q;

endmodule

// File: tb/tb_wt_arb_fsm.sv
// Directed bench for wt_arb_fsm: table of per-cycle vectors plus hand-written burst sequences.
module tb_wt_arb_fsm;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 4;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] reqData;
    logic                    full;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ack;
    logic                    wtEn;
    logic [DATA_W-1:0]       wtData;
    logic                    err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       full;
        logic [3:0] seq;
        logic [3:0] gnt;
        logic       en;
        logic [3:0] ack;
        logic       err;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    wt_arb_fsm #(.N_REQ(N_REQ), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
        .wt_clk             (clk),
        .rst_wt             (rst),
        .req                (req),
        .req_data           (reqData),
        .full               (full),
        .gnt                (gnt),
        .ack                (ack),
        .wt_en              (wtEn),
        .wt_data            (wtData),
        .push_on_full_error (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic r, input logic [3:0] rq, input logic f,
                                   input logic [3:0] s, input logic [3:0] g, input logic e,
                                   input logic [3:0] a, input logic er, input logic [7:0] d);
        vec_t v;
        v.rst = r; v.req = rq; v.full = f; v.seq = s;
        v.gnt = g; v.en = e; v.ack = a; v.err = er; v.data = d;
        return v;
    endfunction

    // Requester i presents {i, seq} so the data byte identifies both owner and beat.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic f,
                                 input logic [3:0] s);
        rst  = r;
        req  = rq;
        full = f;
        for (int i = 0; i < N_REQ; i++) begin
            reqData[i*DATA_W +: DATA_W] = {4'(i), s};
        end
    endtask

    task automatic cmp(input string name, input int step, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s @%0d: got %h want %h", name, step, got, want);
        end
    endtask

    task automatic checkOutput(input int step, input logic [3:0] eGnt, input logic eEn,
                               input logic [3:0] eAck, input logic eErr, input logic [7:0] eData);
        cmp("gnt", step, 8'(gnt), 8'(eGnt));
        cmp("wt_en", step, 8'(wtEn), 8'(eEn));
        cmp("ack", step, 8'(ack), 8'(eAck));
        cmp("error", step, 8'(err), 8'(eErr));
        if (eEn || eGnt == 4'b0000) begin
            cmp("wt_data", step, wtData, eEn ? eData : 8'h00);
        end
    endtask

    task automatic cycle(input int step, input logic r, input logic [3:0] rq, input logic f,
                         input logic [3:0] s, input logic [3:0] eGnt, input logic eEn,
                         input logic [3:0] eAck, input logic eErr, input logic [7:0] eData);
        applyStimulus(r, rq, f, s);
        @(negedge clk);
        checkOutput(step, eGnt, eEn, eAck, eErr, eData);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int step;
        // Reset held with all requests up, then first grant to req[0].
        vecs.push_back(mkVec(1, 4'hF, 0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
        vecs.push_back(mkVec(1, 4'hF, 0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
        vecs.push_back(mkVec(0, 4'hF, 0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
        // Full rotation: four beats per owner, one idle cycle between owners.
        for (int o = 0; o < 4; o++) begin
            for (int b = 0; b < 4; b++) begin
                vecs.push_back(mkVec(0, 4'hF, 0, 4'(b), 4'(1 << o), 1, 4'(1 << o), 0,
                                     {4'(o), 4'(b)}));
            end
            vecs.push_back(mkVec(0, 4'hF, 0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
        end
        // Wrap back to req[0]; it releases after two beats.
        vecs.push_back(mkVec(0, 4'hF, 0, 0, 4'h1, 1, 4'h1, 0, 8'h00));
        vecs.push_back(mkVec(0, 4'hF, 0, 1, 4'h1, 1, 4'h1, 0, 8'h01));
        vecs.push_back(mkVec(0, 4'hE, 0, 2, 4'h1, 0, 4'h0, 0, 8'h00));
        vecs.push_back(mkVec(0, 4'hE, 0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
        // req[1]: full for three cycles at beat 2, error pulses trail by one cycle.
        vecs.push_back(mkVec(0, 4'hE, 0, 0, 4'h2, 1, 4'h2, 0, 8'h10));
        vecs.push_back(mkVec(0, 4'hE, 0, 1, 4'h2, 1, 4'h2, 0, 8'h11));
        vecs.push_back(mkVec(0, 4'hE, 1, 2, 4'h2, 0, 4'h0, 0, 8'h00));
        vecs.push_back(mkVec(0, 4'hE, 1, 2, 4'h2, 0, 4'h0, 1, 8'h00));
        vecs.push_back(mkVec(0, 4'hE, 1, 2, 4'h2, 0, 4'h0, 1, 8'h00));
        vecs.push_back(mkVec(0, 4'hE, 0, 2, 4'h2, 0, 4'h0, 1, 8'h00));
        vecs.push_back(mkVec(0, 4'hE, 0, 2, 4'h2, 1, 4'h2, 0, 8'h12));
        vecs.push_back(mkVec(0, 4'hE, 0, 3, 4'h2, 1, 4'h2, 0, 8'h13));
        vecs.push_back(mkVec(0, 4'hE, 0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
        // req[2] burst interrupted by reset on beat 3; restart must favour req[0].
        vecs.push_back(mkVec(0, 4'hF, 0, 0, 4'h4, 1, 4'h4, 0, 8'h20));
        vecs.push_back(mkVec(0, 4'hF, 0, 1, 4'h4, 1, 4'h4, 0, 8'h21));
        vecs.push_back(mkVec(0, 4'hF, 0, 2, 4'h4, 1, 4'h4, 0, 8'h22));
        vecs.push_back(mkVec(1, 4'hF, 0, 3, 4'h4, 1, 4'h4, 0, 8'h23));
        vecs.push_back(mkVec(0, 4'hF, 0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
        vecs.push_back(mkVec(0, 4'hF, 0, 0, 4'h1, 1, 4'h1, 0, 8'h00));

        applyStimulus(1, 4'hF, 0, 0);
        @(posedge clk);
        #1;
        step = 0;
        foreach (vecs[i]) begin
            cycle(step, vecs[i].rst, vecs[i].req, vecs[i].full, vecs[i].seq,
                  vecs[i].gnt, vecs[i].en, vecs[i].ack, vecs[i].err, vecs[i].data);
            step++;
        end

        // Single requester: repeated 4-beat bursts to req[2] separated by one idle cycle.
        applyStimulus(1, 4'h4, 0, 0);
        @(posedge clk);
        #1;
        for (int b = 0; b < 3; b++) begin
            cycle(step++, 0, 4'h4, 0, 0, 4'h0, 0, 4'h0, 0, 8'h00);
            for (int k = 0; k < BURST_MAX; k++) begin
                cycle(step++, 0, 4'h4, 0, 4'(k), 4'h4, 1, 4'h4, 0, 8'h20 + 8'(k));
            end
        end

        // Full coinciding with the last beat: beat waits for full to drop, then completes.
        cycle(step++, 0, 4'h4, 0, 0, 4'h0, 0, 4'h0, 0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            cycle(step++, 0, 4'h4, 0, 4'(k), 4'h4, 1, 4'h4, 0, 8'h20 + 8'(k));
        end
        cycle(step++, 0, 4'h4, 1, 3, 4'h4, 0, 4'h0, 0, 8'h00);
        cycle(step++, 0, 4'h4, 0, 3, 4'h4, 0, 4'h0, 1, 8'h00);
        cycle(step++, 0, 4'h4, 0, 3, 4'h4, 1, 4'h4, 0, 8'h23);
        cycle(step++, 0, 4'h4, 0, 0, 4'h0, 0, 4'h0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
